capture_sequencer: RTL and testbench

Record-capture controller sitting downstream of the trigger generator in the ADQ214 acquisition path. It manages the pre-trigger FIFO fill, raises `trigger_ready` once enough pre-trigger sample pairs are buffered, and on each `trigger_start` pulse streams a fixed-length record (pre-trigger plus post-trigger pairs) to the storage path. It then re-arms for the next record until the requested record count is reached.

---
 rtl/capture_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer: record-capture controller for the pre-trigger FIFO.
// Phases per record: fill the pre-trigger FIFO, wait for a trigger, then
// stream PRE_TRIG+REC_LEN pairs to storage. After each record it re-arms
// until num_records records are stored; num_records==0 runs continuously.
// Optional feature macro: CAPTURE_SEQ_AUTOTRIG_EN. When it is defined, a
// trigger is forced after TIMEOUT cycles in WAIT_TRIG and is flagged on
// `forced`. When it is undefined, `forced` stays 0.
// All outputs are registered. They are computed from the next state, so
// each output lines up with the state it describes.
module capture_sequencer #(
  parameter int PRE_TRIG = 10,
  parameter int REC_LEN  = 1024,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             arm,
  input  logic             trigger_start,
  input  logic [CNT_W-1:0] num_records,
  output logic             trigger_ready,
  output logic             fifo_rd_en,
  output logic             store_en,
  output logic             record_start,
  output logic             record_done,
  output logic             acq_done,
  output logic             busy,
  output logic             forced,
  output logic [CNT_W-1:0] record_cnt
);

  localparam int TOTAL = PRE_TRIG + REC_LEN;
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0]    FILL_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0]    CAP_LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0]    CAP_PENULT = CW'(TOTAL - 2);
  localparam logic [CW-1:0]    CW_ONE     = CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_TRIG, CAPTURE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    fill_cnt_reg, fill_cnt_next;
  logic [CW-1:0]    cap_cnt_reg, cap_cnt_next;
  logic [CNT_W-1:0] record_cnt_reg, record_cnt_next;
  logic             forced_reg, forced_next;
  logic             record_start_reg, record_start_next;
  logic             record_done_reg, record_done_next;
  logic             acq_done_reg, acq_done_next;
  logic             trigger_ready_reg, fifo_rd_en_reg, store_en_reg, busy_reg;
  logic             auto_fire;

`ifdef CAPTURE_SEQ_AUTOTRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TW_ONE  = TW'(1);

  logic [TW-1:0] to_cnt_reg;

  // Timeout counter: counts cycles spent in WAIT_TRIG and restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt_reg <= '0;
    else if (state_reg == WAIT_TRIG)
      to_cnt_reg <= to_cnt_reg + TW_ONE;
    else
      to_cnt_reg <= '0;
  end

  assign auto_fire = (state_reg == WAIT_TRIG) && (to_cnt_reg == TO_LAST);
`else
  // Without auto-trigger, WAIT_TRIG waits for a real trigger indefinitely.
  // TIMEOUT is still referenced here so the parameter list stays uniform.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign auto_fire      = 1'b0;
`endif

  // Next-state, counter and pulse logic. A low capture_en overrides everything.
  always_comb begin
    state_next        = state_reg;
    fill_cnt_next     = fill_cnt_reg;
    cap_cnt_next      = cap_cnt_reg;
    record_cnt_next   = record_cnt_reg;
    forced_next       = forced_reg;
    record_start_next = 1'b0;
    record_done_next  = 1'b0;
    acq_done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next      = FILL;
          fill_cnt_next   = '0;
          record_cnt_next = '0;
          forced_next     = 1'b0;
        end
      end
      FILL: begin
        fill_cnt_next = fill_cnt_reg + CW_ONE;
        if (fill_cnt_reg == FILL_LAST)
          state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        // A real trigger takes priority over a timeout on the same cycle.
        if (trigger_start || auto_fire) begin
          state_next        = CAPTURE;
          cap_cnt_next      = '0;
          record_start_next = 1'b1;
          forced_next       = !trigger_start;
        end
      end
      CAPTURE: begin
        cap_cnt_next = cap_cnt_reg + CW_ONE;
        // Prepare the last-cycle pulses one cycle early so they are registered.
        if (cap_cnt_reg == CAP_PENULT) begin
          record_done_next = 1'b1;
          record_cnt_next  = record_cnt_reg + CNT_ONE;
          acq_done_next    = (num_records != '0) &&
                             ((record_cnt_reg + CNT_ONE) == num_records);
        end
        if (cap_cnt_reg == CAP_LAST) begin
          state_next    = acq_done_reg ? IDLE : FILL;
          fill_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // An abort discards the partial record: no pulses and no count update.
    if (!capture_en) begin
      state_next        = IDLE;
      record_cnt_next   = record_cnt_reg;
      forced_next       = forced_reg;
      record_start_next = 1'b0;
      record_done_next  = 1'b0;
      acq_done_next     = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      fill_cnt_reg      <= '0;
      cap_cnt_reg       <= '0;
      record_cnt_reg    <= '0;
      forced_reg        <= 1'b0;
      record_start_reg  <= 1'b0;
      record_done_reg   <= 1'b0;
      acq_done_reg      <= 1'b0;
      trigger_ready_reg <= 1'b0;
      fifo_rd_en_reg    <= 1'b0;
      store_en_reg      <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      fill_cnt_reg      <= fill_cnt_next;
      cap_cnt_reg       <= cap_cnt_next;
      record_cnt_reg    <= record_cnt_next;
      forced_reg        <= forced_next;
      record_start_reg  <= record_start_next;
      record_done_reg   <= record_done_next;
      acq_done_reg      <= acq_done_next;
      trigger_ready_reg <= (state_next == WAIT_TRIG);
      fifo_rd_en_reg    <= (state_next == WAIT_TRIG) || (state_next == CAPTURE);
      store_en_reg      <= (state_next == CAPTURE);
      busy_reg          <= (state_next != IDLE);
    end
  end

  assign trigger_ready = trigger_ready_reg;
  assign fifo_rd_en    = fifo_rd_en_reg;
  assign store_en      = store_en_reg;
  assign record_start  = record_start_reg;
  assign record_done   = record_done_reg;
  assign acq_done      = acq_done_reg;
  assign busy          = busy_reg;
  assign forced        = forced_reg;
  assign record_cnt    = record_cnt_reg;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer (PRE_TRIG=10, REC_LEN=16).
// Each trigger pushes the expected record (done cycle, count, acq_done)
// onto a scoreboard. A negedge monitor pops and compares on record_done.
// A cycle index is the value of cyc during that cycle. Inputs are driven
// 1 time unit after posedge and outputs are sampled on negedge.
module tb_capture_sequencer;
  localparam int PRE = 10;
  localparam int REC = 16;
  localparam int LEN = PRE + REC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        arm = 1'b0;
  logic        trigger_start = 1'b0;
  logic [15:0] num_records = '0;
  logic        trigger_ready, fifo_rd_en, store_en, record_start;
  logic        record_done, acq_done, busy, forced;
  logic [15:0] record_cnt;

  capture_sequencer #(.PRE_TRIG(PRE), .REC_LEN(REC), .CNT_W(16), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .arm(arm),
    .trigger_start(trigger_start), .num_records(num_records),
    .trigger_ready(trigger_ready), .fifo_rd_en(fifo_rd_en), .store_en(store_en),
    .record_start(record_start), .record_done(record_done), .acq_done(acq_done),
    .busy(busy), .forced(forced), .record_cnt(record_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int done_cyc; int cnt; bit acq; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   store_len = 0;

  // Scoreboard monitor: one line per completed record.
  always @(negedge clk) begin
    if (rst) begin
      store_len = 0;
    end else begin
      if (record_start) store_len = 1;
      else if (store_en) store_len = store_len + 1;
      if (record_done) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_done: record_done at cycle %0d, none expected", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          $display("record_done cyc=%0d record_cnt=%0d acq_done=%0b len=%0d forced=%0b",
                   cyc, record_cnt, acq_done, store_len, forced);
          checks++;
          if (cyc !== mon_e.done_cyc) begin
            failures++; $display("FAIL sb_done_cycle: got %0d expected %0d", cyc, mon_e.done_cyc);
          end
          checks++;
          if (int'(record_cnt) !== mon_e.cnt) begin
            failures++; $display("FAIL sb_record_cnt: got %0d expected %0d", record_cnt, mon_e.cnt);
          end
          checks++;
          if (acq_done !== mon_e.acq) begin
            failures++; $display("FAIL sb_acq_done: got %b expected %b", acq_done, mon_e.acq);
          end
          checks++;
          if (store_len !== LEN) begin
            failures++; $display("FAIL sb_record_len: got %0d expected %0d", store_len, LEN);
          end
        end
      end else if (acq_done) begin
        checks++; failures++;
        $display("FAIL sb_stray_acq_done: acq_done without record_done at cycle %0d", cyc);
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the first cycle with trigger_ready high, or -1 after 200 cycles.
  task automatic wait_ready(output int rise);
    rise = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (trigger_ready === 1'b1) begin
        rise = cyc;
        break;
      end
    end
    if (rise < 0) begin
      checks++; failures++;
      $display("FAIL wait_ready_timeout: trigger_ready got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic pulse_arm(output int c0);
    c0 = cyc;
    arm = 1'b1;
    goto(c0 + 1);
    arm = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (trigger_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", trigger_ready); end
    checks++; if (store_en !== 1'b0) begin failures++; $display("FAIL reset_store_en: got %b expected 0", store_en); end
    checks++; if (record_cnt !== 16'd0) begin failures++; $display("FAIL reset_record_cnt: got %0d expected 0", record_cnt); end
    checks++; if (forced !== 1'b0) begin failures++; $display("FAIL reset_forced: got %b expected 0", forced); end
    @(posedge clk); #1;
    rst = 1'b0;
    // arm while disabled is ignored
    arm = 1'b1;
    goto(cyc + 1);
    arm = 1'b0;
    capture_en = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_arm_disabled: busy got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    int c0, r;
    num_records = 16'd1;
    pulse_arm(c0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_ready(r);
    checks++; if (r !== c0 + 11) begin failures++; $display("FAIL single_ready_cycle: got %0d expected %0d", r, c0 + 11); end
    goto(c0 + 20);
    trigger_start = 1'b1;
    sb_q.push_back('{done_cyc: c0 + 46, cnt: 1, acq: 1'b1});
    goto(c0 + 21);
    trigger_start = 1'b0;
    @(negedge clk);
    checks++; if ({store_en, record_start, trigger_ready} !== 3'b110) begin
      failures++; $display("FAIL single_capture_start: store/start/ready got %b expected 110", {store_en, record_start, trigger_ready});
    end
    goto(c0 + 46);
    @(negedge clk);
    checks++; if (store_en !== 1'b1) begin failures++; $display("FAIL single_last_store: got %b expected 1", store_en); end
    goto(c0 + 47);
    @(negedge clk);
    checks++; if ({busy, store_en} !== 2'b00) begin failures++; $display("FAIL single_idle: busy/store got %b expected 00", {busy, store_en}); end
    checks++; if (record_cnt !== 16'd1) begin failures++; $display("FAIL single_record_cnt: got %0d expected 1", record_cnt); end
    $display("test_single done");
  endtask

  task automatic test_multi;
    int c0, r, t, last_done;
    num_records = 16'd3;
    last_done = -1;
    pulse_arm(c0);
    for (int i = 0; i < 3; i++) begin
      wait_ready(r);
      if (i > 0) begin
        checks++;
        if (r - last_done - 1 !== PRE) begin
          failures++; $display("FAIL multi_ready_gap: low cycles got %0d expected %0d", r - last_done - 1, PRE);
        end
      end
      t = r + 5;
      goto(t);
      trigger_start = 1'b1;
      sb_q.push_back('{done_cyc: t + LEN, cnt: i + 1, acq: (i == 2)});
      goto(t + 1);
      trigger_start = 1'b0;
      last_done = t + LEN;
      goto(last_done);
    end
    goto(last_done + 1);
    @(negedge clk);
    checks++; if (record_cnt !== 16'd3) begin failures++; $display("FAIL multi_record_cnt: got %0d expected 3", record_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multi_idle: busy got %b expected 0", busy); end
    $display("test_multi done");
  endtask

  task automatic test_ignored_triggers;
    int c0, r, t, d;
    num_records = 16'd2;
    pulse_arm(c0);
    goto(c0 + 4);
    trigger_start = 1'b1;
    goto(c0 + 5);
    trigger_start = 1'b0;
    wait_ready(r);
    checks++; if (r !== c0 + 11) begin failures++; $display("FAIL ignore_fill_ready: got %0d expected %0d", r, c0 + 11); end
    t = r + 2;
    goto(t);
    trigger_start = 1'b1;
    sb_q.push_back('{done_cyc: t + LEN, cnt: 1, acq: 1'b0});
    goto(t + 1);
    trigger_start = 1'b0;
    goto(t + 8);
    trigger_start = 1'b1;
    goto(t + 9);
    trigger_start = 1'b0;
    goto(t + 20);
    trigger_start = 1'b1;
    goto(t + 21);
    trigger_start = 1'b0;
    d = t + LEN;
    goto(d);
    @(negedge clk);
    checks++; if (record_cnt !== 16'd1) begin failures++; $display("FAIL ignore_cnt_first: got %0d expected 1", record_cnt); end
    goto(d + 3);
    trigger_start = 1'b1;
    goto(d + 4);
    trigger_start = 1'b0;
    wait_ready(r);
    checks++; if (r !== d + PRE + 1) begin failures++; $display("FAIL ignore_refill_ready: got %0d expected %0d", r, d + PRE + 1); end
    t = r + 1;
    goto(t);
    trigger_start = 1'b1;
    sb_q.push_back('{done_cyc: t + LEN, cnt: 2, acq: 1'b1});
    goto(t + 1);
    trigger_start = 1'b0;
    goto(t + LEN + 1);
    @(negedge clk);
    checks++; if ({busy, record_cnt} !== {1'b0, 16'd2}) begin
      failures++; $display("FAIL ignore_final: busy/cnt got %b/%0d expected 0/2", busy, record_cnt);
    end
    $display("test_ignored_triggers done");
  endtask

  task automatic test_abort;
    int c0, r, t;
    num_records = 16'd0;
    pulse_arm(c0);
    wait_ready(r);
    t = r + 1;
    goto(t);
    trigger_start = 1'b1;
    sb_q.push_back('{done_cyc: t + LEN, cnt: 1, acq: 1'b0});
    goto(t + 1);
    trigger_start = 1'b0;
    wait_ready(r);
    checks++; if (r !== t + LEN + PRE + 1) begin failures++; $display("FAIL abort_continuous_rearm: got %0d expected %0d", r, t + LEN + PRE + 1); end
    t = r + 1;
    goto(t);
    trigger_start = 1'b1;
    goto(t + 1);
    trigger_start = 1'b0;
    goto(t + 8);
    capture_en = 1'b0;
    goto(t + 9);
    @(negedge clk);
    checks++; if ({busy, store_en, fifo_rd_en, record_done} !== 4'b0000) begin
      failures++; $display("FAIL abort_idle: busy/store/rd/done got %b expected 0000", {busy, store_en, fifo_rd_en, record_done});
    end
    checks++; if (record_cnt !== 16'd1) begin failures++; $display("FAIL abort_record_cnt: got %0d expected 1", record_cnt); end
    goto(t + 30);
    capture_en = 1'b1;
    $display("test_abort done");
  endtask

  task automatic test_rst_wait;
    int c0, r;
    num_records = 16'd0;
    pulse_arm(c0);
    wait_ready(r);
    goto(r + 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, trigger_ready, fifo_rd_en, store_en} !== 4'b0000) begin
      failures++; $display("FAIL rst_async: busy/ready/rd/store got %b expected 0000", {busy, trigger_ready, fifo_rd_en, store_en});
    end
    goto(cyc + 2);
    rst = 1'b0;
    pulse_arm(c0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_rearm_busy: got %b expected 1", busy); end
    wait_ready(r);
    checks++; if (r !== c0 + PRE + 1) begin failures++; $display("FAIL rst_refill: got %0d expected %0d", r, c0 + PRE + 1); end
    goto(r + 1);
    capture_en = 1'b0;
    goto(r + 2);
    capture_en = 1'b1;
    $display("test_rst_wait done");
  endtask

`ifdef CAPTURE_SEQ_AUTOTRIG_EN
  task automatic test_autotrig;
    int c0, r, t;
    num_records = 16'd2;
    pulse_arm(c0);
    wait_ready(r);
    sb_q.push_back('{done_cyc: r + 50 + LEN - 1, cnt: 1, acq: 1'b0});
    goto(r + 49);
    @(negedge clk);
    checks++; if ({trigger_ready, store_en} !== 2'b10) begin failures++; $display("FAIL auto_before: ready/store got %b expected 10", {trigger_ready, store_en}); end
    goto(r + 50);
    @(negedge clk);
    checks++; if ({record_start, forced} !== 2'b11) begin failures++; $display("FAIL auto_forced_start: start/forced got %b expected 11", {record_start, forced}); end
    wait_ready(r);
    t = r + 3;
    goto(t);
    trigger_start = 1'b1;
    sb_q.push_back('{done_cyc: t + LEN, cnt: 2, acq: 1'b1});
    goto(t + 1);
    trigger_start = 1'b0;
    @(negedge clk);
    checks++; if ({record_start, forced} !== 2'b10) begin failures++; $display("FAIL auto_real_clears: start/forced got %b expected 10", {record_start, forced}); end
    goto(t + LEN + 1);
    $display("test_autotrig done");
  endtask
`else
  task automatic test_autotrig;
    int c0, r;
    num_records = 16'd1;
    pulse_arm(c0);
    wait_ready(r);
    goto(r + 80);
    @(negedge clk);
    checks++; if ({trigger_ready, store_en, forced} !== 3'b100) begin
      failures++; $display("FAIL noauto_wait: ready/store/forced got %b expected 100", {trigger_ready, store_en, forced});
    end
    goto(r + 81);
    capture_en = 1'b0;
    goto(r + 82);
    capture_en = 1'b1;
    $display("test_autotrig (disabled build) done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_ignored_triggers();
    test_abort();
    test_rst_wait();
    test_autotrig();
    goto(cyc + 5);
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: pending records got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
